// File: rtl/ysyx_25060170_exu_mc.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_25060170_exu_mc
// Brief    : Multi-cycle execute unit with valid/ready handshakes, registered
//            results and branch decision. Define YSYX_25060170_EXU_MULDIV_EN
//            to build the iterative unsigned mul/divu/remu datapath.
// Revision : 1.0
// ============================================================================
module ysyx_25060170_exu_mc #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_op,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [2:0]      br_op,
    input  logic            is_jal,
    input  logic            is_jalr,
    input  logic [XLEN-1:0] imm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] res,
    output logic            br_taken,
    output logic [XLEN-1:0] jump_addr
);
    localparam int SHW = $clog2(XLEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_accept;
    logic [SHW-1:0]  w_shamt;
    logic [XLEN-1:0] w_alu_res;
    logic [XLEN:0]   w_bsub;
    logic            w_cond;
    logic            w_br_taken;
    logic [XLEN-1:0] w_jsum;
    logic [XLEN-1:0] w_jump;
    logic [XLEN-1:0] r_res;
    logic            r_br;
    logic [XLEN-1:0] r_jump;

    assign in_ready  = (r_state == IDLE) || ((r_state == DONE) && out_ready);
    assign w_accept  = in_valid && in_ready && !flush;
    assign out_valid = (r_state == DONE);
    assign res       = r_res;
    assign br_taken  = r_br;
    assign jump_addr = r_jump;
    assign w_shamt   = op2[SHW-1:0];

`ifdef YSYX_25060170_EXU_MULDIV_EN
    logic [SHW-1:0]  r_cnt;
    logic [XLEN-1:0] r_x;
    logic [XLEN-1:0] r_y;
    logic [XLEN-1:0] r_acc;
    logic            r_is_rem;
    logic            w_start_mul;
    logic            w_start_div;
    logic [XLEN-1:0] w_mul_acc;
    logic [XLEN:0]   w_rsh;
    logic [XLEN:0]   w_diff;
    logic            w_ge;
    logic [XLEN-1:0] w_rem_nxt;
    logic [XLEN-1:0] w_quo_nxt;

    assign w_start_mul = (alu_op == 4'd2);
    assign w_start_div = ((alu_op == 4'd3) || (alu_op == 4'd10)) && (op2 != '0);
    // r_x/r_y hold multiplicand/multiplier or quotient/divisor; r_acc is product or remainder
    assign w_mul_acc   = r_acc + (r_y[0] ? r_x : '0);
    assign w_rsh       = {r_acc, r_x[XLEN-1]};
    assign w_diff      = w_rsh - {1'b0, r_y};
    assign w_ge        = !w_diff[XLEN];
    assign w_rem_nxt   = w_ge ? w_diff[XLEN-1:0] : w_rsh[XLEN-1:0];
    assign w_quo_nxt   = {r_x[XLEN-2:0], w_ge};
`endif

    always_comb begin
        w_alu_res = '0;
        case (alu_op)
            4'd0:  w_alu_res = op1 + op2;
            4'd1:  w_alu_res = op1 - op2;
`ifdef YSYX_25060170_EXU_MULDIV_EN
            // Only reached on divide by zero; nonzero divisors go through DIV
            4'd3:  w_alu_res = '1;
            4'd10: w_alu_res = op1;
`endif
            4'd4:  w_alu_res = op1 & op2;
            4'd5:  w_alu_res = op1 | op2;
            4'd6:  w_alu_res = op1 ^ op2;
            4'd7:  w_alu_res = op1;
            4'd8:  w_alu_res = op1 << w_shamt;
            4'd9:  w_alu_res = op1 >> w_shamt;
            4'd11: w_alu_res = $unsigned($signed(op1) >>> w_shamt);
            4'd12: w_alu_res = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(op2))};
            4'd13: w_alu_res = {{(XLEN-1){1'b0}}, (op1 < op2)};
            default: w_alu_res = '0;
        endcase
    end

    assign w_bsub = {1'b0, rs1} - {1'b0, rs2};

    always_comb begin
        w_cond = 1'b0;
        case (br_op)
            3'd1: w_cond = (rs1 == rs2);
            3'd2: w_cond = (rs1 != rs2);
            3'd3: w_cond = ($signed(rs1) < $signed(rs2));
            3'd4: w_cond = ($signed(rs1) >= $signed(rs2));
            3'd5: w_cond = w_bsub[XLEN];
            3'd6: w_cond = !w_bsub[XLEN];
            default: w_cond = 1'b0;
        endcase
    end

    assign w_br_taken = w_cond || is_jal || is_jalr;
    assign w_jsum     = op1 + imm;
    assign w_jump     = is_jalr ? {w_jsum[XLEN-1:1], 1'b0} : (is_jal ? w_jsum : '0);

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = IDLE;
        end else if (w_accept) begin
            w_state_nxt = DONE;
`ifdef YSYX_25060170_EXU_MULDIV_EN
            if (w_start_mul) begin
                w_state_nxt = MUL;
            end else if (w_start_div) begin
                w_state_nxt = DIV;
            end
`endif
        end else begin
            case (r_state)
                DONE: if (out_ready) w_state_nxt = IDLE;
`ifdef YSYX_25060170_EXU_MULDIV_EN
                MUL, DIV: if (r_cnt == '0) w_state_nxt = DONE;
`endif
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_res  <= '0;
            r_br   <= 1'b0;
            r_jump <= '0;
        end else if (w_accept) begin
            r_res  <= w_alu_res;
            r_br   <= w_br_taken;
            r_jump <= w_jump;
        end
`ifdef YSYX_25060170_EXU_MULDIV_EN
        else if (!flush && (r_state == MUL) && (r_cnt == '0)) begin
            r_res <= w_mul_acc;
        end else if (!flush && (r_state == DIV) && (r_cnt == '0)) begin
            r_res <= r_is_rem ? w_rem_nxt : w_quo_nxt;
        end
`endif
    end

`ifdef YSYX_25060170_EXU_MULDIV_EN
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_cnt    <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_acc    <= '0;
            r_is_rem <= 1'b0;
        end else if (w_accept) begin
            r_cnt    <= (w_start_mul || w_start_div) ? SHW'(XLEN-1) : '0;
            r_x      <= op1;
            r_y      <= op2;
            r_acc    <= '0;
            r_is_rem <= (alu_op == 4'd10);
        end else if (r_state == MUL) begin
            r_acc <= w_mul_acc;
            r_x   <= r_x << 1;
            r_y   <= r_y >> 1;
            if (r_cnt != '0) r_cnt <= r_cnt - SHW'(1);
        end else if (r_state == DIV) begin
            r_acc <= w_rem_nxt;
            r_x   <= w_quo_nxt;
            if (r_cnt != '0) r_cnt <= r_cnt - SHW'(1);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ysyx_25060170_exu_mc.sv
`default_nettype none
// Testbench for ysyx_25060170_exu_mc: directed and random ops, queue scoreboard
// against a behavioural model; adapts to YSYX_25060170_EXU_MULDIV_EN.
module tb_ysyx_25060170_exu_mc;
    localparam int XLEN = 32;
`ifdef YSYX_25060170_EXU_MULDIV_EN
    localparam bit MULDIV = 1'b1;
`else
    localparam bit MULDIV = 1'b0;
`endif

    logic        clk, rst, flush, in_valid, in_ready, is_jal, is_jalr;
    logic        out_valid, out_ready, br_taken;
    logic [3:0]  alu_op;
    logic [2:0]  br_op;
    logic [31:0] op1, op2, rs1, rs2, imm, res, jump_addr;

    ysyx_25060170_exu_mc #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .op1(op1), .op2(op2), .rs1(rs1), .rs2(rs2), .br_op(br_op),
        .is_jal(is_jal), .is_jalr(is_jalr), .imm(imm), .out_valid(out_valid),
        .out_ready(out_ready), .res(res), .br_taken(br_taken), .jump_addr(jump_addr)
    );

    typedef struct {
        logic [31:0] e_res;
        logic        e_br;
        logic [31:0] e_ja;
        int          acc;
        int          lat;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   head_seen = 0;
    int   rmode = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // out_ready policy: 0 always ready, 1 random, 2 held low
    initial forever begin
        @(posedge clk);
        #2;
        case (rmode)
            1: out_ready = ($urandom_range(0, 2) != 0);
            2: out_ready = 1'b0;
            default: out_ready = 1'b1;
        endcase
    end

    function automatic logic [31:0] m_res(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0]        p;
        logic signed [31:0] sa;
        int                 sh;
        sa = a;
        sh = int'(b[4:0]);
        p  = {32'd0, a} * {32'd0, b};
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return MULDIV ? p[31:0] : 32'd0;
            4'd3:  return !MULDIV ? 32'd0 : ((b == 0) ? 32'hFFFF_FFFF : a / b);
            4'd4:  return a & b;
            4'd5:  return a | b;
            4'd6:  return a ^ b;
            4'd7:  return a;
            4'd8:  return a << sh;
            4'd9:  return a >> sh;
            4'd10: return !MULDIV ? 32'd0 : ((b == 0) ? a : a % b);
            4'd11: return sa >>> sh;
            4'd12: return (sa < $signed(b)) ? 32'd1 : 32'd0;
            4'd13: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic m_br(input logic [2:0] bo, input logic [31:0] a,
                                  input logic [31:0] b, input logic j, input logic jr);
        logic c;
        case (bo)
            3'd1: c = (a == b);
            3'd2: c = (a != b);
            3'd3: c = ($signed(a) < $signed(b));
            3'd4: c = ($signed(a) >= $signed(b));
            3'd5: c = (a < b);
            3'd6: c = (a >= b);
            default: c = 1'b0;
        endcase
        return c | j | jr;
    endfunction

    function automatic int m_lat(input logic [3:0] op, input logic [31:0] b);
        if (MULDIV && (op == 4'd2 || ((op == 4'd3 || op == 4'd10) && b != 0))) return XLEN + 1;
        return 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Monitor: compares the head of the queue whenever a result is presented
    initial forever begin
        @(negedge clk);
        if (!rst && out_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got out_valid=1 res=0x%08h expected no result", res);
            end else begin
                if (!head_seen) begin
                    check("latency", 32'(cyc - q[0].acc), 32'(q[0].lat));
                    head_seen = 1;
                end
                check("res", res, q[0].e_res);
                check("br_taken", 32'(br_taken), 32'(q[0].e_br));
                check("jump_addr", jump_addr, q[0].e_ja);
                if (!out_ready) begin
                    check("in_ready_hold", 32'(in_ready), 32'd0);
                end else begin
                    void'(q.pop_front());
                    head_seen = 0;
                end
            end
        end
    end

    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r1, input logic [31:0] r2, input logic [2:0] bo,
                        input logic j, input logic jr, input logic [31:0] im);
        exp_t e;
        alu_op = op; op1 = a; op2 = b; rs1 = r1; rs2 = r2; br_op = bo;
        is_jal = j; is_jalr = jr; imm = im; in_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) begin
                e.e_res = m_res(op, a, b);
                e.e_br  = m_br(bo, r1, r2, j, jr);
                e.e_ja  = jr ? ((a + im) & 32'hFFFF_FFFE) : (j ? a + im : 32'd0);
                e.acc   = cyc;
                e.lat   = m_lat(op, b);
                q.push_back(e);
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        checks++;
        errors++;
        $display("FAIL accept_timeout: got in_ready=0 for 200 cycles expected accept");
    endtask

    task automatic drain();
        int k = 0;
        while (q.size() != 0 && k < 500) begin
            @(posedge clk);
            k++;
        end
        #1;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  op;
        logic [31:0] a, b;
        int          jsel;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        alu_op = '0; op1 = '0; op2 = '0; rs1 = '0; rs2 = '0; br_op = '0;
        is_jal = 1'b0; is_jalr = 1'b0; imm = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_res", res, 32'd0);
        check("rst_br_taken", 32'(br_taken), 32'd0);
        check("rst_jump_addr", jump_addr, 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        send(4'd0, 32'h7FFF_FFFF, 32'd1, 0, 0, 3'd0, 0, 0, 0);
        send(4'd11, 32'h8000_0000, 32'd4, 0, 0, 3'd0, 0, 0, 0);
        send(4'd1, 32'd5, 32'd7, 0, 0, 3'd0, 0, 0, 0);
        send(4'd13, 32'd1, 32'hFFFF_FFFF, 0, 0, 3'd0, 0, 0, 0);
        send(4'd12, 32'hFFFF_FFFF, 32'd1, 0, 0, 3'd0, 0, 0, 0);

        send(4'd2, 32'h0001_0000, 32'h0001_0000, 0, 0, 3'd0, 0, 0, 0);
`ifdef YSYX_25060170_EXU_MULDIV_EN
        for (int k = 0; k < XLEN; k++) begin
            @(negedge clk);
            check("in_ready_busy", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
`endif
        send(4'd2, 32'd1234, 32'd5678, 0, 0, 3'd0, 0, 0, 0);
        send(4'd3, 32'd100, 32'd7, 0, 0, 3'd0, 0, 0, 0);
        send(4'd10, 32'd100, 32'd7, 0, 0, 3'd0, 0, 0, 0);
        send(4'd3, 32'd5, 32'd0, 0, 0, 3'd0, 0, 0, 0);
        send(4'd10, 32'd5, 32'd0, 0, 0, 3'd0, 0, 0, 0);

        send(4'd0, 0, 0, 32'd1, 32'hFFFF_FFFF, 3'd5, 0, 0, 0);
        send(4'd0, 0, 0, 32'd1, 32'hFFFF_FFFF, 3'd3, 0, 0, 0);
        send(4'd0, 32'h8000_0003, 0, 0, 0, 3'd0, 0, 1, 32'd4);
        send(4'd0, 32'h0000_1000, 0, 0, 0, 3'd0, 1, 0, 32'h21);
        send(4'd2, 32'd3, 32'd4, 0, 0, 3'd0, 0, 0, 0);
        drain();

        // Result held in DONE while out_ready is low
        rmode = 2;
        send(4'd6, 32'hA5A5_0F0F, 32'h0FF0_FF00, 32'd7, 32'd7, 3'd1, 0, 0, 0);
        repeat (6) @(posedge clk);
        #1;
        rmode = 0;
        drain();

        // Flush ten cycles into a divide
        send(4'd3, 32'd100, 32'd7, 0, 0, 3'd0, 0, 0, 0);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        q.delete();
        head_seen = 0;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        repeat (40) @(posedge clk);
        #1;

        // Accept coinciding with flush is dropped
        alu_op = 4'd0; op1 = 32'd1; op2 = 32'd1; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        check("flush_accept_drop", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

        rmode = 1;
        for (int n = 0; n < 120; n++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1, 2: b = $urandom_range(1, 1000);
                default: b = $urandom;
            endcase
            jsel = $urandom_range(0, 5);
            send(op, a, b, $urandom, ($urandom_range(0, 3) == 0) ? a : $urandom,
                 3'($urandom_range(0, 7)), jsel == 0, jsel == 1, $urandom);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        rmode = 0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
